// File: rtl/axi_rd_port_arb.sv
// axi_rd_port_arb: NPORT-client AXI3 read arbiter, one outstanding single-beat read per port, tagged arid = port index.
// Optional feature macro AXI_RD_ARB_RR_EN selects round-robin grants; when undefined the lowest eligible port wins.
module axi_rd_port_arb #(
   parameter int NPORT  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   // Client side: req_ready is a one-cycle combinational grant pulse while req_valid is held;
   // resp_valid is a one-cycle pulse that clients must accept (no back-pressure).
   input  logic [NPORT-1:0]        req_valid,
   input  logic [NPORT*ADDR_W-1:0] req_addr,
   output logic [NPORT-1:0]        req_ready,
   output logic [NPORT-1:0]        resp_valid,
   output logic [NPORT*DATA_W-1:0] resp_data,
   output logic [NPORT-1:0]        resp_err,
   output logic [NPORT-1:0]        busy,
   output logic                    unexp_rid,
   output logic [ID_W-1:0]         arid,
   output logic [ADDR_W-1:0]       araddr,
   output logic [3:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic [1:0]              arlock,
   output logic [3:0]              arcache,
   output logic [2:0]              arprot,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_W-1:0]         rid,
   input  logic [DATA_W-1:0]       rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready,
   output logic                    ar_state
);

   typedef enum logic {
      AR_IDLE  = 1'b0,
      AR_ISSUE = 1'b1
   } ar_state_e;

   ar_state_e            state_q, state_d;
   logic [NPORT-1:0]     eligible;
   logic                 grant_any;
   logic [ID_W-1:0]      grant_idx;
   logic [ADDR_W-1:0]    grant_addr;
   logic                 take;
   logic                 r_fire;
   logic [NPORT-1:0]     r_hit;

   assign arlen    = 4'd0;
   assign arsize   = 3'($clog2(DATA_W / 8));
   assign arburst  = 2'b01;
   assign arlock   = 2'b00;
   assign arcache  = 4'd0;
   assign arprot   = 3'd0;
   assign rready   = 1'b1;
   assign ar_state = (state_q == AR_ISSUE);

   // busy is registered, so a port whose response is landing this cycle is still excluded.
   assign eligible = req_valid & ~busy;

`ifdef AXI_RD_ARB_RR_EN
   localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

   logic [PTR_W-1:0] ptr_q;

   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NPORT; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NPORT) idx = idx - NPORT;
         if (!grant_any && eligible[idx[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_q <= '0;
      end else if (take) begin
         ptr_q <= (int'(grant_idx) + 1 >= NPORT) ? '0 : PTR_W'(int'(grant_idx) + 1);
      end
   end
`else
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int i = NPORT - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
   end
`endif

   // Gating with resetn keeps req_ready low while reset is held, even with requests pending.
   assign take = (state_q == AR_IDLE) && grant_any && resetn;

   always_comb begin
      req_ready  = '0;
      grant_addr = '0;
      for (int p = 0; p < NPORT; p++) begin
         req_ready[p] = take && (grant_idx == ID_W'(p));
         if (grant_idx == ID_W'(p)) grant_addr = req_addr[p*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         AR_IDLE:  if (take) state_d = AR_ISSUE;
         AR_ISSUE: if (arvalid && arready) state_d = AR_IDLE;
         default:  state_d = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= AR_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arvalid <= 1'b0;
         araddr  <= '0;
         arid    <= '0;
      end else if (take) begin
         arvalid <= 1'b1;
         araddr  <= grant_addr;
         arid    <= grant_idx;
      end else if (arvalid && arready) begin
         arvalid <= 1'b0;
      end
   end

   // Beats without rlast are protocol errors for single-beat reads and are ignored outright.
   assign r_fire = rvalid && rlast;

   always_comb begin
      r_hit = '0;
      for (int p = 0; p < NPORT; p++) begin
         r_hit[p] = r_fire && (rid == ID_W'(p)) && busy[p];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy       <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         resp_err   <= '0;
         unexp_rid  <= 1'b0;
      end else begin
         busy       <= (busy | req_ready) & ~r_hit;
         resp_valid <= r_hit;
         unexp_rid  <= unexp_rid | (r_fire && (r_hit == '0));
         for (int p = 0; p < NPORT; p++) begin
            if (r_hit[p]) begin
               resp_data[p*DATA_W +: DATA_W] <= rdata;
               resp_err[p]                   <= (rresp != 2'b00);
            end
         end
      end
   end

   a_ar_hold: assert property (@(posedge clk) disable iff (!resetn)
      (arvalid && !arready) |=> (arvalid && $stable(araddr) && $stable(arid)));

   a_grant_onehot: assert property (@(posedge clk) disable iff (!resetn)
      $onehot0(req_ready));

   a_grant_not_busy: assert property (@(posedge clk) disable iff (!resetn)
      (req_ready & busy) == '0);

endmodule

// File: tb/tb_axi_rd_port_arb.sv
// Directed bench for axi_rd_port_arb: stimulus pushes expected AR beats and client responses into
// queues, and a negedge monitor pops and compares whenever the DUT handshakes AR or pulses resp_valid.
`timescale 1ns/1ps
module tb_axi_rd_port_arb;
   localparam int NPORT  = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;
   localparam int AR_W   = ID_W + ADDR_W;
   localparam int RS_W   = ID_W + 1 + DATA_W;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   logic                    rv [NPORT];
   logic [ADDR_W-1:0]       ra [NPORT];
   logic [NPORT-1:0]        req_valid;
   logic [NPORT*ADDR_W-1:0] req_addr;
   logic [NPORT-1:0]        req_ready, resp_valid, resp_err, busy;
   logic [NPORT*DATA_W-1:0] resp_data;
   logic                    unexp_rid;
   logic [ID_W-1:0]         arid, rid;
   logic [ADDR_W-1:0]       araddr;
   logic [3:0]              arlen, arcache;
   logic [2:0]              arsize, arprot;
   logic [1:0]              arburst, arlock, rresp;
   logic                    arvalid, arready, rready, rlast, rvalid, ar_state;
   logic [DATA_W-1:0]       rdata;

   logic [AR_W-1:0] exp_ar[$];
   logic [RS_W-1:0] exp_resp[$];
   logic [AR_W-1:0] pend_q[$];
   logic            auto_resp = 1'b0;
   int              n_checks = 0;
   int              n_err = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         req_valid[p]                  = rv[p];
         req_addr[p*ADDR_W +: ADDR_W]  = ra[p];
      end
   end

   axi_rd_port_arb #(.NPORT(NPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .busy(busy), .unexp_rid(unexp_rid),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .ar_state(ar_state)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ar(input int id, input logic [ADDR_W-1:0] a);
      exp_ar.push_back({ID_W'(id), a});
   endtask

   task automatic push_resp(input int id, input logic err, input logic [DATA_W-1:0] d);
      exp_resp.push_back({ID_W'(id), err, d});
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [AR_W-1:0] ea;
      logic [RS_W-1:0] er;
      if (resetn && arvalid && arready) begin
         if (exp_ar.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL ar_unexpected: got arid=%0d araddr=%h, expected none", arid, araddr);
         end else begin
            ea = exp_ar.pop_front();
            check("ar_beat", {arid, araddr}, ea);
         end
      end
      for (int p = 0; p < NPORT; p++) begin
         if (resp_valid[p]) begin
            if (exp_resp.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL resp_unexpected: got port %0d data %h, expected none", p, resp_data[p*DATA_W +: DATA_W]);
            end else begin
               er = exp_resp.pop_front();
               check("resp", {ID_W'(p), resp_err[p], resp_data[p*DATA_W +: DATA_W]}, er);
            end
         end
      end
   end

   // Simple R-channel slave: answers each accepted AR one cycle later with rdata = ~araddr.
   always @(negedge clk) begin
      if (auto_resp && resetn && arvalid && arready) pend_q.push_back({arid, araddr});
   end

   initial begin
      logic [AR_W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (auto_resp) begin
            if (pend_q.size() > 0) begin
               e      = pend_q.pop_front();
               rvalid = 1'b1;
               rlast  = 1'b1;
               rid    = e[AR_W-1:ADDR_W];
               rdata  = ~e[ADDR_W-1:0];
               rresp  = 2'b00;
            end else begin
               rvalid = 1'b0;
               rlast  = 1'b0;
            end
         end
      end
   end

   task automatic port_reads(input int p, input int n, input logic [ADDR_W-1:0] base);
      logic got;
      for (int k = 0; k < n; k++) begin
         got   = 1'b0;
         rv[p] = 1'b1;
         ra[p] = base + ADDR_W'(4 * k);
         for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1'b1;
            tick();
         end
         if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL grant_timeout: port %0d read %0d got no req_ready, expected one within 200 cycles", p, k);
         end
      end
      rv[p] = 1'b0;
   endtask

   task automatic r_beat(input int id, input logic [DATA_W-1:0] d, input logic [1:0] rs, input logic last);
      rvalid = 1'b1;
      rlast  = last;
      rid    = ID_W'(id);
      rdata  = d;
      rresp  = rs;
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
   endtask

   task automatic drain();
      int c;
      c = 0;
      while ((exp_ar.size() > 0 || exp_resp.size() > 0) && c < 500) begin
         tick();
         c++;
      end
      n_checks++;
      if (exp_ar.size() > 0 || exp_resp.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d ar and %0d resp still pending, expected 0", exp_ar.size(), exp_resp.size());
      end
   endtask

   task automatic reset_dut();
      resetn = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      tick();
   endtask

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int p = 0; p < NPORT; p++) begin
         rv[p] = 1'b0;
         ra[p] = '0;
      end
      arready = 1'b1;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rid     = '0;
      rdata   = '0;
      rresp   = 2'b00;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      tick();

      // 1: reset while an AR is stalled
      arready = 1'b0;
      rv[0]   = 1'b1;
      ra[0]   = 32'h0abc_0000;
      @(negedge clk) check("t1_grant", req_ready, 2'b01);
      tick();
      @(negedge clk) check("t1_arvalid", arvalid, 1'b1);
      tick();
      resetn = 1'b0;
      #1;
      check("t1_rst_arvalid", arvalid, 1'b0);
      check("t1_rst_araddr", araddr, '0);
      check("t1_rst_arid", arid, '0);
      check("t1_rst_req_ready", req_ready, '0);
      check("t1_rst_resp_valid", resp_valid, '0);
      check("t1_rst_resp_data", resp_data, '0);
      check("t1_rst_resp_err", resp_err, '0);
      check("t1_rst_busy", busy, '0);
      check("t1_rst_unexp", unexp_rid, 1'b0);
      check("t1_rst_state", ar_state, 1'b0);
      check("t1_const_ar", {arlen, arsize, arburst, arlock, arcache, arprot}, {4'd0, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0});
      check("t1_rready", rready, 1'b1);
      tick();
      rv[0]   = 1'b0;
      resetn  = 1'b1;
      arready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_idle", {arvalid, req_ready, busy}, '0);
         tick();
      end

      // 2: single read on port 0
      rv[0] = 1'b1;
      ra[0] = 32'h1c00_0010;
      push_ar(0, 32'h1c00_0010);
      push_resp(0, 1'b0, 32'hdead_beef);
      @(negedge clk) check("t2_req_ready", req_ready, 2'b01);
      tick();
      rv[0] = 1'b0;
      @(negedge clk);
      check("t2_arvalid_t1", arvalid, 1'b1);
      check("t2_busy_set", busy, 2'b01);
      tick();
      r_beat(0, 32'hdead_beef, 2'b00, 1'b1);
      @(negedge clk);
      check("t2_resp_pulse", resp_valid, 2'b01);
      check("t2_busy_clr", busy, 2'b00);
      tick();
      drain();

      // 3a: both ports stream 4 reads each; the forced alternation is identical for both policies
      reset_dut();
      auto_resp = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_ar(0, 32'h1000_0000 + 32'(4 * k));
         push_ar(1, 32'h2000_0000 + 32'(4 * k));
      end
      for (int k = 0; k < 4; k++) begin
         push_resp(0, 1'b0, ~(32'h1000_0000 + 32'(4 * k)));
         push_resp(1, 1'b0, ~(32'h2000_0000 + 32'(4 * k)));
      end
      fork
         port_reads(0, 4, 32'h1000_0000);
         port_reads(1, 4, 32'h2000_0000);
      join
      drain();

      // 3b: port 0 alone, then both together; this is where the policies diverge
      push_ar(0, 32'h3000_0000);
      push_resp(0, 1'b0, ~32'h3000_0000);
      port_reads(0, 1, 32'h3000_0000);
      drain();
      repeat (2) tick();
`ifdef AXI_RD_ARB_RR_EN
      push_ar(1, 32'h3000_0200);
      push_ar(0, 32'h3000_0100);
      push_resp(1, 1'b0, ~32'h3000_0200);
      push_resp(0, 1'b0, ~32'h3000_0100);
`else
      push_ar(0, 32'h3000_0100);
      push_ar(1, 32'h3000_0200);
      push_resp(0, 1'b0, ~32'h3000_0100);
      push_resp(1, 1'b0, ~32'h3000_0200);
`endif
      fork
         port_reads(0, 1, 32'h3000_0100);
         port_reads(1, 1, 32'h3000_0200);
      join
      drain();
      repeat (2) tick();
      auto_resp = 1'b0;
      rvalid    = 1'b0;
      rlast     = 1'b0;
      tick();

      // 4: out-of-order return with an error response on port 0
      push_ar(0, 32'h4000_0000);
      push_ar(1, 32'h4000_0004);
      push_resp(1, 1'b0, 32'h0000_0011);
      push_resp(0, 1'b1, 32'h0000_0022);
      port_reads(0, 1, 32'h4000_0000);
      port_reads(1, 1, 32'h4000_0004);
      r_beat(1, 32'h0000_0011, 2'b00, 1'b1);
      r_beat(0, 32'h0000_0022, 2'b10, 1'b1);
      tick();
      drain();
      check("t4_err_hold", resp_err, 2'b01);

      // 5: AR stalled for 5 cycles with another port waiting
      arready = 1'b0;
      rv[1]   = 1'b1;
      ra[1]   = 32'h5000_0000;
      push_ar(1, 32'h5000_0000);
      push_ar(0, 32'h5000_0008);
      push_resp(1, 1'b0, 32'h0000_0055);
      push_resp(0, 1'b0, 32'h0000_0066);
      @(negedge clk) check("t5_grant1", req_ready, 2'b10);
      tick();
      rv[0] = 1'b1;
      ra[0] = 32'h5000_0008;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t5_hold_arvalid", {ar_state, arvalid}, 2'b11);
         check("t5_hold_araddr", araddr, 32'h5000_0000);
         check("t5_hold_arid", arid, 4'd1);
         check("t5_hold_no_grant", req_ready, 2'b00);
         tick();
      end
      arready = 1'b1;
      @(negedge clk) check("t5_hs_no_grant", req_ready, 2'b00);
      tick();
      @(negedge clk) check("t5_grant0", req_ready, 2'b01);
      tick();
      rv[0] = 1'b0;
      rv[1] = 1'b0;
      r_beat(1, 32'h0000_0055, 2'b00, 1'b1);
      r_beat(0, 32'h0000_0066, 2'b00, 1'b1);
      tick();
      drain();

      // 6: unexpected rid handling, rlast-less beats, reset mid-operation
      reset_dut();
      check("t6_unexp_init", unexp_rid, 1'b0);
      r_beat(3, 32'h0000_0033, 2'b00, 1'b1);
      @(negedge clk);
      check("t6_unexp_rid3", unexp_rid, 1'b1);
      check("t6_no_resp_rid3", resp_valid, 2'b00);
      tick();
      reset_dut();
      check("t6_unexp_cleared", unexp_rid, 1'b0);
      r_beat(0, 32'h0000_0044, 2'b00, 1'b1);
      @(negedge clk) check("t6_unexp_idle_rid0", unexp_rid, 1'b1);
      repeat (3) tick();
      @(negedge clk) check("t6_unexp_sticky", unexp_rid, 1'b1);
      tick();
      reset_dut();
      push_ar(0, 32'h6000_0000);
      port_reads(0, 1, 32'h6000_0000);
      tick();
      r_beat(0, 32'h0000_0077, 2'b00, 1'b0);
      @(negedge clk);
      check("t6_nolast_no_resp", resp_valid, 2'b00);
      check("t6_nolast_busy", busy, 2'b01);
      check("t6_nolast_unexp", unexp_rid, 1'b0);
      tick();
      resetn = 1'b0;
      #1 check("t6_midop_busy", busy, 2'b00);
      tick();
      resetn = 1'b1;
      tick();
      r_beat(0, 32'h0000_0088, 2'b00, 1'b1);
      @(negedge clk);
      check("t6_late_unexp", unexp_rid, 1'b1);
      check("t6_late_no_resp", resp_valid, 2'b00);
      tick();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
